// File: rtl/sorcerer_uart_tx.sv
// sorcerer_uart_tx: FIFO-buffered async serial transmitter for the RS-232 port; define SORCERER_UART_PARITY_EN for a parity bit
module sorcerer_uart_tx #(
  parameter int FIFO_AW = 2,
  parameter int DIV_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
`ifdef SORCERER_UART_PARITY_EN
  input  logic             parity_en,
  input  logic             parity_odd,
`endif
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
`ifdef SORCERER_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_d, data_exit;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] level;
  logic push, pop, bit_done, stop2_q, tx_d, busy_d;
  logic [7:0] shift;
  logic [DIV_W-1:0] div_q, baud_cnt;
  logic [2:0] bit_cnt;
`ifdef SORCERER_UART_PARITY_EN
  logic par_en_q, par_q;
  assign data_exit = par_en_q ? PARITY : STOP;
`else
  assign data_exit = STOP;
`endif
  assign din_ready = level != LVL_FULL;
  assign fifo_level = level;
  assign push = din_valid & din_ready;
  assign pop = state == IDLE && level != '0;
  assign bit_done = baud_cnt == div_q - DIV_ONE;
  // FIFO storage; contents need no reset because the pointers define what is valid
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end
  // FIFO pointers and occupancy; push and pop on one edge cancel out
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      level <= push && !pop ? level + LVL_ONE : pop && !push ? level - LVL_ONE : level;
    end
  end
  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  // FSM next state; STOP ends after one or two stop bits counted in bit_cnt
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = pop ? START : IDLE;
      START:   state_d = bit_done ? DATA : START;
      DATA:    state_d = bit_done && bit_cnt == 3'd7 ? data_exit : DATA;
`ifdef SORCERER_UART_PARITY_EN
      PARITY:  state_d = bit_done ? STOP : PARITY;
`endif
      STOP:    state_d = bit_done && bit_cnt[0] == stop2_q ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // frame datapath: load on pop, then count baud cycles and bits
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      shift <= '0;
      div_q <= DIV_ONE;
      stop2_q <= 1'b0;
      baud_cnt <= '0;
      bit_cnt <= '0;
`ifdef SORCERER_UART_PARITY_EN
      par_en_q <= 1'b0;
      par_q <= 1'b0;
`endif
    end else if (pop) begin
      shift <= mem[rd_ptr];
      div_q <= baud_div == '0 ? DIV_ONE : baud_div;
      stop2_q <= stop2;
      baud_cnt <= '0;
      bit_cnt <= '0;
`ifdef SORCERER_UART_PARITY_EN
      par_en_q <= parity_en;
      par_q <= ^mem[rd_ptr] ^ parity_odd;
`endif
    end else if (state != IDLE) begin
      baud_cnt <= bit_done ? '0 : baud_cnt + DIV_ONE;
      if (bit_done && state == DATA) shift <= shift >> 1;
      if (bit_done && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 3'd1;
    end
  end
  // FSM outputs: line level for the current state, busy while anything is pending
  always_comb begin
`ifdef SORCERER_UART_PARITY_EN
    tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_q : 1'b1;
`else
    tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
    busy_d = state != IDLE || level != '0;
  end
  // registered outputs keep tx free of combinational paths from the inputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx <= tx_d;
      busy <= busy_d;
    end
  end
endmodule

// File: tb/tb_sorcerer_uart_tx.sv
// tb_sorcerer_uart_tx: table vectors, corner sequences and random traffic against a line-level model
module tb_sorcerer_uart_tx;
  typedef struct {
    logic [7:0] data;
    int div;
    bit stop2;
    bit pen;
    bit podd;
    int exp_len;
    int exp_ones;
    int exp_low;
  } vec_t;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic stop2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic din_valid = 1'b0;
  logic din_ready, tx, busy;
  logic [2:0] fifo_level;
`ifdef SORCERER_UART_PARITY_EN
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] fq[$];
  bit lq[$];
  bit m_tx = 1'b1;
  bit m_busy = 1'b0;
  vec_t vecs[$];

  sorcerer_uart_tx dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .baud_div(baud_div),
    .stop2(stop2),
`ifdef SORCERER_UART_PARITY_EN
    .parity_en(parity_en),
    .parity_odd(parity_odd),
`endif
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .tx(tx),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected line: a queue of per-cycle levels appended whole frames at a time
  function automatic void add_frame(input logic [7:0] b);
    int d;
    bit bits[$];
    d = baud_div == 16'd0 ? 1 : int'(baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef SORCERER_UART_PARITY_EN
    if (parity_en) bits.push_back(^b ^ parity_odd);
`endif
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < d; j++) lq.push_back(bits[k]);
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fq.delete();
      lq.delete();
      m_tx = 1'b1;
      m_busy = 1'b0;
    end else begin
      automatic int lvl = fq.size();
      automatic bit do_pop = lq.size() == 0 && lvl > 0;
      automatic bit do_push = din_valid && lvl < 4;
      m_busy = lq.size() != 0 || lvl != 0;
      if (lq.size() != 0) m_tx = lq.pop_front();
      else m_tx = 1'b1;
      if (do_pop) add_frame(fq.pop_front());
      if (do_push) fq.push_back(din);
    end
  end

  always @(negedge clk_sys) begin
    check("mon_tx", int'(tx), int'(m_tx));
    check("mon_busy", int'(busy), int'(m_busy));
    check("mon_level", int'(fifo_level), fq.size());
    check("mon_ready", int'(din_ready), int'(fq.size() < 4));
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    int g = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && g < 5000) begin
      @(negedge clk_sys);
      g++;
    end
    if (g == 5000) check("push_timeout", int'(din_ready), 1);
    @(negedge clk_sys);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 5000) begin
      @(negedge clk_sys);
      g++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    vecs.push_back('{8'hA5, 4, 1'b0, 1'b0, 1'b0, 40, 20, 4});
    vecs.push_back('{8'h00, 3, 1'b1, 1'b0, 1'b0, 33, 6, 27});
    vecs.push_back('{8'hFF, 0, 1'b0, 1'b0, 1'b0, 10, 9, 1});
    vecs.push_back('{8'h55, 2, 1'b1, 1'b0, 1'b0, 22, 12, 2});
    vecs.push_back('{8'h01, 1, 1'b0, 1'b0, 1'b0, 10, 2, 1});
    vecs.push_back('{8'h80, 5, 1'b1, 1'b0, 1'b0, 55, 15, 40});
`ifdef SORCERER_UART_PARITY_EN
    vecs.push_back('{8'hA5, 4, 1'b0, 1'b1, 1'b0, 44, 20, 4});
    vecs.push_back('{8'hA5, 4, 1'b0, 1'b1, 1'b1, 44, 24, 4});
`endif
    repeat (3) @(negedge clk_sys);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ready", int'(din_ready), 1);
    reset = 1'b0;
    @(negedge clk_sys);
    baud_div = 16'd4;
    stop2 = 1'b0;
    din = 8'hA5;
    din_valid = 1'b1;
    @(negedge clk_sys);
    din_valid = 1'b0;
    check("lat_e0_tx", int'(tx), 1);
    check("lat_e0_busy", int'(busy), 0);
    @(negedge clk_sys);
    check("lat_e1_tx", int'(tx), 1);
    check("lat_e1_busy", int'(busy), 1);
    @(negedge clk_sys);
    check("lat_e2_tx", int'(tx), 0);
    wait_idle();
    foreach (vecs[v]) begin
      int len, ones, low, g;
      bit seen_high;
      wait_idle();
      baud_div = 16'(vecs[v].div);
      stop2 = vecs[v].stop2;
`ifdef SORCERER_UART_PARITY_EN
      parity_en = vecs[v].pen;
      parity_odd = vecs[v].podd;
`endif
      push(vecs[v].data);
      g = 0;
      while (tx && g < 100) begin
        @(negedge clk_sys);
        g++;
      end
      check("vec_start", int'(tx), 0);
      baud_div = 16'($urandom_range(1, 7));
      stop2 = 1'($urandom);
      len = 0;
      ones = 0;
      low = 0;
      seen_high = 1'b0;
      while (busy && len < 1000) begin
        len++;
        ones += int'(tx);
        if (tx) seen_high = 1'b1;
        else if (!seen_high) low++;
        @(negedge clk_sys);
      end
      check($sformatf("vec%0d_len", v), len, vecs[v].exp_len);
      check($sformatf("vec%0d_ones", v), ones, vecs[v].exp_ones);
      check($sformatf("vec%0d_low", v), low, vecs[v].exp_low);
    end
`ifdef SORCERER_UART_PARITY_EN
    parity_en = 1'b0;
    parity_odd = 1'b0;
`endif
    wait_idle();
    baud_div = 16'd2;
    stop2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = 8'h30 + 8'(i);
      din_valid = 1'b1;
      if (i < 5) begin
        check($sformatf("bp_ready%0d", i), int'(din_ready), 1);
        @(negedge clk_sys);
      end else begin
        check("bp_full_ready", int'(din_ready), 0);
        check("bp_full_level", int'(fifo_level), 4);
      end
    end
    begin
      int g = 0;
      while (!din_ready && g < 1000) begin
        @(negedge clk_sys);
        g++;
      end
      check("bp_hold_accept", int'(din_ready), 1);
      @(negedge clk_sys);
      din_valid = 1'b0;
    end
    wait_idle();
    baud_div = 16'd4;
    stop2 = 1'b0;
    push(8'h55);
    push(8'h12);
    push(8'h34);
    repeat (8) @(negedge clk_sys);
    check("mid_level", int'(fifo_level), 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(din_ready), 1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk_sys);
        if (!tx || busy) bad++;
      end
      check("no_restart", bad, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      din_valid = $urandom_range(0, 7) == 0;
      din = 8'($urandom);
      baud_div = 16'($urandom_range(0, 3));
      stop2 = 1'($urandom);
`ifdef SORCERER_UART_PARITY_EN
      parity_en = 1'($urandom);
      parity_odd = 1'($urandom);
`endif
      @(negedge clk_sys);
    end
    din_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk_sys);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
